// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK for R-type, lw, sw and jalr.
// Owns PC, IR, ALU/MDR latches, the retire counter and the memory-handshake timeout.
module multicycle_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  input  logic [31:0] alu_result,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        retire,
  output logic [31:0] retired_count,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0]  OP_R    = 7'b0110011;
  localparam logic [6:0]  OP_LW   = 7'b0000011;
  localparam logic [6:0]  OP_SW   = 7'b0100011;
  localparam logic [6:0]  OP_JALR = 7'b1100111;
  localparam logic [31:0] TMO_LIMIT = 32'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic        fetch_req;

  logic        is_r, is_lw, is_sw, is_jalr, tmo_hit;
  logic [31:0] pc_plus4;

  assign is_r     = (ir_q[6:0] == OP_R);
  assign is_lw    = (ir_q[6:0] == OP_LW);
  assign is_sw    = (ir_q[6:0] == OP_SW);
  assign is_jalr  = (ir_q[6:0] == OP_JALR);
  assign pc_plus4 = pc_q + 32'd4;
  // The cycle whose miss would bring the count to the limit is the last one allowed.
  assign tmo_hit  = (TMO_LIMIT != 32'd0) && ((tmo_cnt_q + 32'd1) == TMO_LIMIT);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    alu_out_d       = alu_out_q;
    mdr_d           = mdr_q;
    tmo_cnt_d       = tmo_cnt_q;
    trap_cause_d    = trap_cause_q;
    fetch_req       = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    alu_src_imm     = 1'b0;
    alu_op          = 2'b00;
    reg_write       = 1'b0;
    wb_sel          = 2'b00;
    retire          = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b11;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (is_r || is_lw || is_sw || is_jalr) begin
          state_d = S_EXECUTE;
        end else begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b01;
        end
      end
      S_EXECUTE: begin
        alu_out_d   = alu_result;
        alu_src_imm = !is_r;
        alu_op      = is_r ? 2'b10 : 2'b00;
        if (is_lw || is_sw) begin
          state_d   = S_MEM;
          tmo_cnt_d = 32'd0;
        end else if (is_jalr && alu_result[1]) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            pc_d      = pc_plus4;
            retire    = 1'b1;
            state_d   = S_FETCH;
            tmo_cnt_d = 32'd0;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WRITEBACK;
          end
        end else if (tmo_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b11;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_WRITEBACK: begin
        reg_write = (ir_q[11:7] != 5'd0);
        wb_sel    = is_lw ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
        pc_d      = is_jalr ? {alu_out_q[31:1], 1'b0} : pc_plus4;
        retire    = 1'b1;
        state_d   = S_FETCH;
        tmo_cnt_d = 32'd0;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
    retired_count_d = retired_count_q + {31'd0, retire};
  end

  always_comb begin
    wb_data = 32'd0;
    case (wb_sel)
      2'b00:   wb_data = alu_out_q;
      2'b01:   wb_data = mdr_q;
      2'b10:   wb_data = pc_plus4;
      default: wb_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      ir_q            <= 32'd0;
      alu_out_q       <= 32'd0;
      mdr_q           <= 32'd0;
      retired_count_q <= 32'd0;
      tmo_cnt_q       <= 32'd0;
      trap_cause_q    <= 2'b00;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ir_q            <= ir_d;
      alu_out_q       <= alu_out_d;
      mdr_q           <= mdr_d;
      retired_count_q <= retired_count_d;
      tmo_cnt_q       <= tmo_cnt_d;
      trap_cause_q    <= trap_cause_d;
    end
  end

  // Reset state is FETCH, so the fetch request is masked while rst_n is low.
  assign imem_req      = fetch_req && rst_n;
  assign imem_addr     = pc_q;
  assign dmem_addr     = alu_out_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign retired_count = retired_count_q;
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = trap_cause_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instruction walk per scenario,
// inputs driven on the falling edge and outputs checked just after it.
module tb_multicycle_controller;

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] LW   = 32'h0080A283;
  localparam logic [31:0] SW   = 32'h0020A223;
  localparam logic [31:0] JALR = 32'h000100E7;
  localparam logic [31:0] JAL  = 32'h008000EF;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, alu_result;
  logic [31:0] ir, pc, wb_data, retired_count;
  logic        alu_src_imm, reg_write, retire, trap;
  logic [1:0]  alu_op, wb_sel, trap_cause;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.RESET_PC(32'h100), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .alu_result(alu_result), .ir(ir), .pc(pc),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .wb_data(wb_data), .retire(retire), .retired_count(retired_count), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One call covers one clock cycle: inputs for the edge that ends it, then settle.
  task automatic applyStimulus(input logic i_rdy, input logic [31:0] i_data,
                               input logic d_rdy, input logic [31:0] d_data,
                               input logic [31:0] alu);
    @(negedge clk);
    imem_ready = i_rdy;
    imem_rdata = i_data;
    dmem_ready = d_rdy;
    dmem_rdata = d_data;
    alu_result = alu;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic zeroInputs();
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    alu_result = 32'd0;
  endtask

  // Release lands just after a rising edge so the next applyStimulus owns the first FETCH.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    zeroInputs();
    #1;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_pc", pc, 32'h100);
    checkOutput("rst_trap", 32'(trap), 32'd0);
    checkOutput("rst_cause", 32'(trap_cause), 32'd0);
    checkOutput("rst_retired", retired_count, 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    zeroInputs();
    resetDut();

    // add x3,x1,x2 with zero-wait fetch
    applyStimulus(1'b1, ADD, 1'b0, 32'd0, 32'd0);
    checkOutput("add_f_req", 32'(imem_req), 32'd1);
    checkOutput("add_f_addr", imem_addr, 32'h100);
    checkOutput("add_f_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("add_d_state", 32'(state), 32'd1);
    checkOutput("add_d_rw", 32'(reg_write), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h30);
    checkOutput("add_e_state", 32'(state), 32'd2);
    checkOutput("add_e_src", 32'(alu_src_imm), 32'd0);
    checkOutput("add_e_op", 32'(alu_op), 32'd2);
    checkOutput("add_e_ir", ir, ADD);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h999);
    checkOutput("add_w_state", 32'(state), 32'd4);
    checkOutput("add_w_rw", 32'(reg_write), 32'd1);
    checkOutput("add_w_sel", 32'(wb_sel), 32'd0);
    checkOutput("add_w_data", wb_data, 32'h30);
    checkOutput("add_w_retire", 32'(retire), 32'd1);

    // lw x5,8(x1) with three data wait cycles
    applyStimulus(1'b1, LW, 1'b0, 32'd0, 32'd0);
    checkOutput("add_pc", pc, 32'h104);
    checkOutput("add_imem_addr", imem_addr, 32'h104);
    checkOutput("add_retired", retired_count, 32'd1);
    checkOutput("lw_f_retire", 32'(retire), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h1008);
    checkOutput("lw_e_src", 32'(alu_src_imm), 32'd1);
    checkOutput("lw_e_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'hDEAD0000);
      checkOutput("lw_m_req", 32'(dmem_req), 32'd1);
      checkOutput("lw_m_we", 32'(dmem_we), 32'd0);
      checkOutput("lw_m_addr", dmem_addr, 32'h1008);
      checkOutput("lw_m_state", 32'(state), 32'd3);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 32'hCAFEBABE, 32'd0);
    checkOutput("lw_m4_req", 32'(dmem_req), 32'd1);
    checkOutput("lw_m4_retire", 32'(retire), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h11111111, 32'd0);
    checkOutput("lw_w_state", 32'(state), 32'd4);
    checkOutput("lw_w_sel", 32'(wb_sel), 32'd1);
    checkOutput("lw_w_data", wb_data, 32'hCAFEBABE);
    checkOutput("lw_w_rw", 32'(reg_write), 32'd1);
    checkOutput("lw_w_dreq", 32'(dmem_req), 32'd0);
    checkOutput("lw_w_retire", 32'(retire), 32'd1);

    // sw x2,4(x1): retires from MEM without a register write
    applyStimulus(1'b1, SW, 1'b0, 32'd0, 32'd0);
    checkOutput("lw_pc", pc, 32'h108);
    checkOutput("lw_retired", retired_count, 32'd2);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h2004);
    applyStimulus(1'b0, 32'd0, 1'b1, 32'd0, 32'd0);
    checkOutput("sw_m_req", 32'(dmem_req), 32'd1);
    checkOutput("sw_m_we", 32'(dmem_we), 32'd1);
    checkOutput("sw_m_addr", dmem_addr, 32'h2004);
    checkOutput("sw_m_retire", 32'(retire), 32'd1);
    checkOutput("sw_m_rw", 32'(reg_write), 32'd0);

    // jalr x1,0(x2) to 0x201: bit 0 cleared, link value pc+4
    applyStimulus(1'b1, JALR, 1'b0, 32'd0, 32'd0);
    checkOutput("sw_pc", pc, 32'h10C);
    checkOutput("sw_retired", retired_count, 32'd3);
    checkOutput("sw_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h201);
    checkOutput("jalr_e_src", 32'(alu_src_imm), 32'd1);
    checkOutput("jalr_e_state", 32'(state), 32'd2);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("jalr_w_rw", 32'(reg_write), 32'd1);
    checkOutput("jalr_w_sel", 32'(wb_sel), 32'd2);
    checkOutput("jalr_w_data", wb_data, 32'h110);
    checkOutput("jalr_w_retire", 32'(retire), 32'd1);

    // jal is unsupported: illegal-opcode trap, PC frozen
    applyStimulus(1'b1, JAL, 1'b0, 32'd0, 32'd0);
    checkOutput("jalr_pc", pc, 32'h200);
    checkOutput("jalr_imem_addr", imem_addr, 32'h200);
    checkOutput("jalr_retired", retired_count, 32'd4);
    applyStimulus(1'b1, ADD, 1'b0, 32'd0, 32'd0);
    checkOutput("jal_d_state", 32'(state), 32'd1);
    applyStimulus(1'b1, ADD, 1'b0, 32'd0, 32'd0);
    checkOutput("jal_t_state", 32'(state), 32'd5);
    checkOutput("jal_t_trap", 32'(trap), 32'd1);
    checkOutput("jal_t_cause", 32'(trap_cause), 32'd1);
    checkOutput("jal_t_pc", pc, 32'h200);
    checkOutput("jal_t_ireq", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, ADD, 1'b1, 32'd0, 32'd0);
    checkOutput("jal_t2_state", 32'(state), 32'd5);
    checkOutput("jal_t2_ireq", 32'(imem_req), 32'd0);
    checkOutput("jal_t2_dreq", 32'(dmem_req), 32'd0);
    checkOutput("jal_t2_retired", retired_count, 32'd4);
    resetDut();

    // fetch never ready: timeout trap after four missed cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      checkOutput("tmo_f_req", 32'(imem_req), 32'd1);
      checkOutput("tmo_f_state", 32'(state), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("tmo_state", 32'(state), 32'd5);
    checkOutput("tmo_trap", 32'(trap), 32'd1);
    checkOutput("tmo_cause", 32'(trap_cause), 32'd3);
    checkOutput("tmo_ireq", 32'(imem_req), 32'd0);
    checkOutput("tmo_pc", pc, 32'h100);
    resetDut();

    // ready arriving in the last allowed cycle wins over the timeout
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    end
    applyStimulus(1'b1, ADD, 1'b0, 32'd0, 32'd0);
    checkOutput("late_f_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("late_d_state", 32'(state), 32'd1);
    checkOutput("late_d_trap", 32'(trap), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h5);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("late_w_retire", 32'(retire), 32'd1);

    // reset asserted mid data handshake
    applyStimulus(1'b1, LW, 1'b0, 32'd0, 32'd0);
    checkOutput("mr_f_pc", pc, 32'h104);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h40);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("mr_m_dreq", 32'(dmem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_dreq", 32'(dmem_req), 32'd0);
    checkOutput("mr_ireq", 32'(imem_req), 32'd0);
    checkOutput("mr_state", 32'(state), 32'd0);
    checkOutput("mr_pc", pc, 32'h100);
    checkOutput("mr_ir", ir, 32'd0);
    checkOutput("mr_retired", retired_count, 32'd0);
    checkOutput("mr_wb_data", wb_data, 32'd0);
    checkOutput("mr_daddr", dmem_addr, 32'd0);
    checkOutput("mr_retire", 32'(retire), 32'd0);
    checkOutput("mr_rw", 32'(reg_write), 32'd0);
    checkOutput("mr_trap", 32'(trap), 32'd0);
    zeroInputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("mr_after_ireq", 32'(imem_req), 32'd1);
    checkOutput("mr_after_addr", imem_addr, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
